console_mux: RTL and testbench
==============================

CONSOLE_MUX -- requirements
Module: console_mux

Interface
REQ-001 Parameter NCH, default 2, number of console channels (1..8).
REQ-002 Parameter MAXBURST, default 16, max consecutive command bytes sent while any console byte waits.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_areset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_rx_stb, i_rx_data  in  1, 8  byte from UART receiver.
REQ-006 o_cmd_stb, o_cmd_data  out  1, 7  command-port byte toward bus decoder.
REQ-007 i_cmd_stb, i_cmd_data, o_cmd_busy  in/in/out  1, 7, 1  command-port byte to transmit.
REQ-008 i_console_stb, i_console_data, o_console_busy  in/in/out  NCH, 7*NCH, NCH  per-channel transmit bytes; channel c uses data[7c+6:7c].
REQ-009 o_console_stb, o_console_data  out  NCH, 7  received console byte, stb one-hot by channel.
REQ-010 o_tx_stb, o_tx_data, i_tx_busy  out/out/in  1, 8, 1  byte to UART transmitter.

Function
REQ-011 Byte accepted on any input port when stb high and matching busy low in same cycle.
REQ-012 Rx byte with bit7=1 SHALL produce o_cmd_stb=1, o_cmd_data=rx[6:0] one cycle later, in any rx state.
REQ-013 Rx decoder states: R_DATA, R_SEL; SEL byte = 8'h7F.
REQ-014 R_DATA, rx 8'h7F -> R_SEL, no output; other bit7=0 byte -> o_console_stb[rx_chan]=1, data=rx[6:0], one cycle later.
REQ-015 R_SEL, rx 8'h7F -> literal 7'h7F delivered on rx_chan, -> R_DATA.
REQ-016 R_SEL, rx value n<NCH -> rx_chan=n, no output, -> R_DATA; n>=NCH and n!=8'h7F -> byte dropped, rx_chan unchanged, -> R_DATA.
REQ-017 Each console channel has a one-byte holding register; o_console_busy[c] = hold_full[c].
REQ-018 Command port has a one-byte holding register; o_cmd_busy = cmd_full.
REQ-019 Output register: o_tx_stb = out_full; cleared on any cycle out_full && !i_tx_busy; may reload in that same cycle.
REQ-020 Tx states: T_IDLE, T_SEL, T_NUM, T_DATA, T_ESC.
REQ-021 T_IDLE selection when output register free: cmd_full wins unless burst_cnt==MAXBURST and any hold_full; else round-robin over hold_full starting at channel after last served.
REQ-022 Command byte sent as {1'b1, cmd}; burst_cnt increments (saturating at MAXBURST), cleared when a console byte is sent or no console byte waits.
REQ-023 Console byte on channel c == tx_chan: send {0,data}; if data==7'h7F send 8'h7F then 8'h7F (T_ESC).
REQ-024 Console byte on c != tx_chan: send 8'h7F, then {1'b0, c} (tx_chan <= c), then data per REQ-023.
REQ-025 Sequence T_SEL..T_DATA/T_ESC not interruptible by command bytes; hold_full[c] clears when its final byte loads.
REQ-026 Throughput: one output byte per free output-register cycle; no idle cycle between consecutive sequences.
REQ-027 Simultaneous accept and clear of the same holding register in one cycle SHALL keep register full with new byte.

Reset
REQ-028 On i_areset_n low: o_cmd_stb=0, o_console_stb=0, o_tx_stb=0, all hold_full=0, cmd_full=0, busies low, rx state R_DATA, tx state T_IDLE, rx_chan=tx_chan=0, round-robin pointer 0, burst_cnt=0, data outputs 0.
REQ-029 Reset mid-sequence SHALL abandon the partial byte sequence; first post-reset console byte on channel 0 sends without SEL.

Configuration
REQ-030 Macro CONSOLE_MUX_CMDGATE_EN defined: cmd_active flag, reset 0, set by any rx byte with bit7=1; while 0, cmd byte held (o_cmd_busy=1 once full) and never selected for transmit.
REQ-031 Macro undefined: cmd_active constant 1; command port always eligible.

Verification
REQ-032 Reset, rx 8'h41 -> o_console_stb=2'b01, data 7'h41 next cycle; rx 8'hC1 -> o_cmd_stb, data 7'h41.
REQ-033 rx 7F,01,42 -> one o_console_stb=2'b10 data 7'h42; rx 7F,7F -> literal 7'h7F on channel 1; rx 7F,05 (NCH=2) -> no output.
REQ-034 i_tx_busy=0, console ch1 byte 7'h33 after reset -> tx 8'h7F, 8'h01, 8'h33 consecutive cycles; then ch1 7'h7F -> tx 7F,7F.
REQ-035 Cmd held continuously full, ch0 byte waiting, MAXBURST=4 -> exactly 4 command bytes then ch0 byte.
REQ-036 i_tx_busy=1 for 10 cycles with output full -> o_tx_stb/o_tx_data stable, no byte lost; reset asserted mid-SEL sequence -> all outputs 0 immediately.
REQ-037 With CONSOLE_MUX_CMDGATE_EN: cmd byte before any bit7=1 rx -> not transmitted; after rx 8'h80 -> sent as {1, cmd}.

Source files
------------

// File: rtl/console_mux_if.sv
// Handshake bundle for console_mux: UART rx/tx bytes, the command port and the per-channel console ports.
interface console_mux_if #(
  parameter int NCH = 2
);
  logic             i_rx_stb;
  logic [7:0]       i_rx_data;
  logic             o_cmd_stb;
  logic [6:0]       o_cmd_data;
  logic             i_cmd_stb;
  logic [6:0]       i_cmd_data;
  logic             o_cmd_busy;
  logic [NCH-1:0]   i_console_stb;
  logic [7*NCH-1:0] i_console_data;
  logic [NCH-1:0]   o_console_busy;
  logic [NCH-1:0]   o_console_stb;
  logic [6:0]       o_console_data;
  logic             o_tx_stb;
  logic [7:0]       o_tx_data;
  logic             i_tx_busy;

  modport slave (
    input  i_rx_stb, i_rx_data, i_cmd_stb, i_cmd_data, i_console_stb, i_console_data, i_tx_busy,
    output o_cmd_stb, o_cmd_data, o_cmd_busy, o_console_busy, o_console_stb, o_console_data,
           o_tx_stb, o_tx_data
  );

  modport master (
    output i_rx_stb, i_rx_data, i_cmd_stb, i_cmd_data, i_console_stb, i_console_data, i_tx_busy,
    input  o_cmd_stb, o_cmd_data, o_cmd_busy, o_console_busy, o_console_stb, o_console_data,
           o_tx_stb, o_tx_data
  );
endinterface

// File: rtl/console_mux.sv
// Multiplexes a command port and NCH console channels over one UART byte stream (SEL = 8'h7F escapes).
// Optional macro CONSOLE_MUX_CMDGATE_EN holds the command port closed until an rx byte with bit7 set arrives.
module console_mux #(
  parameter int NCH      = 2,
  parameter int MAXBURST = 16
) (
  input  logic         i_clk,
  input  logic         i_areset_n,
  console_mux_if.slave bus
);
  localparam int         CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int         BW  = $clog2(MAXBURST + 1);
  localparam logic [7:0] SEL = 8'h7F;

  typedef enum logic {R_DATA, R_SEL} rxState_t;
  typedef enum logic [2:0] {T_IDLE, T_SEL, T_NUM, T_DATA, T_ESC} txState_t;

  rxState_t       rxState_q;
  logic [CW-1:0]  rxChan_q;
  logic           cmdOutStb_q;
  logic [6:0]     cmdOutData_q;
  logic [NCH-1:0] conOutStb_q;
  logic [6:0]     conOutData_q;

  txState_t       txState_q;
  logic           outFull_q;
  logic [7:0]     outData_q;
  logic           cmdFull_q;
  logic [6:0]     cmdHold_q;
  logic [NCH-1:0] holdFull_q;
  logic [6:0]     holdData_q [NCH];
  logic [CW-1:0]  txChan_q;
  logic [CW-1:0]  curChan_q;
  logic [CW-1:0]  rrNext_q;
  logic [BW-1:0]  burstCnt_q;

  logic           cmdActive;
  logic           anyHold;
  logic [CW-1:0]  pickChan;
  logic [CW-1:0]  pickNext;
  logic           cmdWins;
  logic           outFree;

`ifdef CONSOLE_MUX_CMDGATE_EN
  logic cmdActive_q;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cmdActive_q <= 1'b0;
    end else if (bus.i_rx_stb && bus.i_rx_data[7]) begin
      cmdActive_q <= 1'b1;
    end
  end

  assign cmdActive = cmdActive_q;
`else
  assign cmdActive = 1'b1;
`endif

  // Receive decoder: bit7 bytes go to the command port in any state; 7F opens a select/escape pair.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rxState_q    <= R_DATA;
      rxChan_q     <= '0;
      cmdOutStb_q  <= 1'b0;
      cmdOutData_q <= '0;
      conOutStb_q  <= '0;
      conOutData_q <= '0;
    end else begin
      cmdOutStb_q <= 1'b0;
      conOutStb_q <= '0;
      if (bus.i_rx_stb) begin
        if (bus.i_rx_data[7]) begin
          cmdOutStb_q  <= 1'b1;
          cmdOutData_q <= bus.i_rx_data[6:0];
        end else if (rxState_q == R_SEL) begin
          rxState_q <= R_DATA;
          if (bus.i_rx_data == SEL) begin
            conOutStb_q[rxChan_q] <= 1'b1;
            conOutData_q          <= 7'h7F;
          end else if (int'(bus.i_rx_data) < NCH) begin
            rxChan_q <= bus.i_rx_data[CW-1:0];
          end
        end else if (bus.i_rx_data == SEL) begin
          rxState_q <= R_SEL;
        end else begin
          conOutStb_q[rxChan_q] <= 1'b1;
          conOutData_q          <= bus.i_rx_data[6:0];
        end
      end
    end
  end

  // Round-robin scan begins at the channel after the one served last.
  always_comb begin
    logic [CW-1:0] idx;
    anyHold  = 1'b0;
    pickChan = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CW'((int'(rrNext_q) + k) % NCH);
      if (!anyHold && holdFull_q[idx]) begin
        anyHold  = 1'b1;
        pickChan = idx;
      end
    end
  end

  assign pickNext = (pickChan == CW'(NCH - 1)) ? '0 : pickChan + 1'b1;
  assign cmdWins  = cmdFull_q && cmdActive && !((burstCnt_q == BW'(MAXBURST)) && anyHold);
  assign outFree  = !outFull_q || !bus.i_tx_busy;

  // Transmit side; a console sequence runs to completion before the command port is looked at again.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      txState_q  <= T_IDLE;
      outFull_q  <= 1'b0;
      outData_q  <= '0;
      cmdFull_q  <= 1'b0;
      cmdHold_q  <= '0;
      holdFull_q <= '0;
      for (int c = 0; c < NCH; c++) holdData_q[c] <= '0;
      txChan_q   <= '0;
      curChan_q  <= '0;
      rrNext_q   <= '0;
      burstCnt_q <= '0;
    end else begin
      if (outFull_q && !bus.i_tx_busy) outFull_q <= 1'b0;
      if (!anyHold) burstCnt_q <= '0;
      if (outFree) begin
        unique case (txState_q)
          T_IDLE: begin
            if (cmdWins) begin
              outFull_q <= 1'b1;
              outData_q <= {1'b1, cmdHold_q};
              cmdFull_q <= 1'b0;
              if (anyHold && burstCnt_q != BW'(MAXBURST)) burstCnt_q <= burstCnt_q + 1'b1;
            end else if (anyHold) begin
              outFull_q  <= 1'b1;
              curChan_q  <= pickChan;
              rrNext_q   <= pickNext;
              burstCnt_q <= '0;
              if (pickChan != txChan_q) begin
                outData_q <= SEL;
                txState_q <= T_SEL;
              end else begin
                outData_q <= {1'b0, holdData_q[pickChan]};
                if (holdData_q[pickChan] == 7'h7F) txState_q <= T_ESC;
                else holdFull_q[pickChan] <= 1'b0;
              end
            end
          end
          T_SEL: begin
            outFull_q <= 1'b1;
            outData_q <= 8'(curChan_q);
            txChan_q  <= curChan_q;
            txState_q <= T_NUM;
          end
          T_NUM: begin
            outFull_q <= 1'b1;
            outData_q <= {1'b0, holdData_q[curChan_q]};
            if (holdData_q[curChan_q] == 7'h7F) begin
              txState_q <= T_ESC;
            end else begin
              holdFull_q[curChan_q] <= 1'b0;
              txState_q             <= T_IDLE;
            end
          end
          T_ESC: begin
            outFull_q             <= 1'b1;
            outData_q             <= SEL;
            holdFull_q[curChan_q] <= 1'b0;
            txState_q             <= T_IDLE;
          end
          default: txState_q <= T_IDLE;
        endcase
      end
      if (bus.i_cmd_stb && !cmdFull_q) begin
        cmdFull_q <= 1'b1;
        cmdHold_q <= bus.i_cmd_data;
      end
      for (int c = 0; c < NCH; c++) begin
        if (bus.i_console_stb[c] && !holdFull_q[c]) begin
          holdFull_q[c] <= 1'b1;
          holdData_q[c] <= bus.i_console_data[7*c +: 7];
        end
      end
    end
  end

  assign bus.o_cmd_stb      = cmdOutStb_q;
  assign bus.o_cmd_data     = cmdOutData_q;
  assign bus.o_cmd_busy     = cmdFull_q;
  assign bus.o_console_busy = holdFull_q;
  assign bus.o_console_stb  = conOutStb_q;
  assign bus.o_console_data = conOutData_q;
  assign bus.o_tx_stb       = outFull_q;
  assign bus.o_tx_data      = outData_q;
endmodule

// File: tb/tb_console_mux.sv
// Scoreboard bench for console_mux: directed scenarios plus randomized traffic against a byte-level model.
module tb_console_mux;
  localparam int NCH      = 2;
  localparam int MAXBURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  console_mux_if #(.NCH(NCH)) bus ();

  console_mux #(.NCH(NCH), .MAXBURST(MAXBURST)) dut (
    .i_clk      (clk),
    .i_areset_n (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] txExpQ [$];
  logic [6:0] cmdExpQ [$];
  int         conChanQ [$];
  logic [6:0] conDataQ [$];

  // Reference model state: receive decoder plus holding registers and a queue of pending sequence bytes.
  int         rxSelMode, rxChan;
  logic       mCmdFull, mCmdActive, mOutFull;
  logic [6:0] mCmd;
  logic [NCH-1:0] mHold;
  logic [6:0] mHoldData [NCH];
  logic [7:0] mOutData;
  logic [7:0] seqQ [$];
  int         mSeqChan, mTxChan, mRR, mBurst;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic noteUnexpected(input string name, input logic [31:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%0h expected=nothing", name, actual);
  endtask

  task automatic modelReset();
    rxSelMode = 0; rxChan = 0;
    mCmdFull = 1'b0; mCmd = '0; mHold = '0; mOutFull = 1'b0; mOutData = '0;
    for (int c = 0; c < NCH; c++) mHoldData[c] = '0;
    mSeqChan = 0; mTxChan = 0; mRR = 0; mBurst = 0;
`ifdef CONSOLE_MUX_CMDGATE_EN
    mCmdActive = 1'b0;
`else
    mCmdActive = 1'b1;
`endif
    seqQ.delete(); txExpQ.delete(); cmdExpQ.delete(); conChanQ.delete(); conDataQ.delete();
  endtask

  task automatic modelStep();
    logic           cmdAcc, anyHold, free, loaded;
    logic [NCH-1:0] conAcc;
    logic [7:0]     ld;
    int             c, idx;
    cmdAcc = bus.i_cmd_stb && !mCmdFull;
    for (int k = 0; k < NCH; k++) conAcc[k] = bus.i_console_stb[k] && !mHold[k];
    anyHold = |mHold;
    free    = !mOutFull || !bus.i_tx_busy;
    loaded  = 1'b0;
    ld      = '0;
    if (!anyHold) mBurst = 0;
    if (free) begin
      if (seqQ.size() > 0) begin
        ld = seqQ.pop_front(); loaded = 1'b1;
        if (seqQ.size() == 0) mHold[mSeqChan] = 1'b0;
      end else if (mCmdFull && mCmdActive && !(mBurst == MAXBURST && anyHold)) begin
        ld = {1'b1, mCmd}; loaded = 1'b1; mCmdFull = 1'b0;
        if (anyHold && mBurst < MAXBURST) mBurst++;
      end else if (anyHold) begin
        c = -1;
        for (int k = 0; k < NCH; k++) begin
          idx = (mRR + k) % NCH;
          if (c < 0 && mHold[idx]) c = idx;
        end
        mRR = (c + 1) % NCH; mBurst = 0;
        if (c != mTxChan) begin
          seqQ.push_back(8'h7F); seqQ.push_back(8'(c)); mTxChan = c;
        end
        seqQ.push_back({1'b0, mHoldData[c]});
        if (mHoldData[c] == 7'h7F) seqQ.push_back(8'h7F);
        mSeqChan = c;
        ld = seqQ.pop_front(); loaded = 1'b1;
        if (seqQ.size() == 0) mHold[c] = 1'b0;
      end
      mOutFull = loaded;
      if (loaded) begin
        mOutData = ld;
        txExpQ.push_back(ld);
      end
    end
    if (cmdAcc) begin mCmdFull = 1'b1; mCmd = bus.i_cmd_data; end
    for (int k = 0; k < NCH; k++)
      if (conAcc[k]) begin mHold[k] = 1'b1; mHoldData[k] = bus.i_console_data[7*k +: 7]; end
    if (bus.i_rx_stb && bus.i_rx_data[7]) mCmdActive = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  // Monitor: pops expectations whenever the DUT presents a byte on one of its output ports.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_cmd_stb) begin
        if (cmdExpQ.size() == 0) noteUnexpected("rx_cmd_byte", 32'(bus.o_cmd_data));
        else checkOutput("rx_cmd_data", 32'(bus.o_cmd_data), 32'(cmdExpQ.pop_front()));
      end
      if (bus.o_console_stb != '0) begin
        if (conChanQ.size() == 0) noteUnexpected("rx_console_byte", 32'(bus.o_console_data));
        else begin
          checkOutput("rx_console_stb", 32'(bus.o_console_stb), 32'(1) << conChanQ.pop_front());
          checkOutput("rx_console_data", 32'(bus.o_console_data), 32'(conDataQ.pop_front()));
        end
      end
      checkOutput("tx_stb", 32'(bus.o_tx_stb), 32'(mOutFull));
      checkOutput("cmd_busy", 32'(bus.o_cmd_busy), 32'(mCmdFull));
      checkOutput("console_busy", 32'(bus.o_console_busy), 32'(mHold));
      if (bus.o_tx_stb && !bus.i_tx_busy) begin
        if (txExpQ.size() == 0) noteUnexpected("tx_byte", 32'(bus.o_tx_data));
        else checkOutput("tx_data", 32'(bus.o_tx_data), 32'(txExpQ.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic rxStb, input logic [7:0] rxData, input logic cmdStb,
                               input logic [6:0] cmdData, input logic [NCH-1:0] conStb,
                               input logic [7*NCH-1:0] conData, input logic txBusy);
    @(posedge clk);
    #1;
    bus.i_rx_stb = rxStb;   bus.i_rx_data = rxData;
    bus.i_cmd_stb = cmdStb; bus.i_cmd_data = cmdData;
    bus.i_console_stb = conStb; bus.i_console_data = conData;
    bus.i_tx_busy = txBusy;
    if (rxStb) begin
      if (rxData[7]) cmdExpQ.push_back(rxData[6:0]);
      else if (rxSelMode != 0) begin
        rxSelMode = 0;
        if (rxData == 8'h7F) begin conChanQ.push_back(rxChan); conDataQ.push_back(7'h7F); end
        else if (int'(rxData) < NCH) rxChan = int'(rxData);
      end else if (rxData == 8'h7F) rxSelMode = 1;
      else begin conChanQ.push_back(rxChan); conDataQ.push_back(rxData[6:0]); end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, '0, '0, 1'b0);
  endtask

  task automatic sendRx(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, 7'h00, '0, '0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tx_stb"}, 32'(bus.o_tx_stb), 0);
    checkOutput({tag, "_tx_data"}, 32'(bus.o_tx_data), 0);
    checkOutput({tag, "_cmd_stb"}, 32'(bus.o_cmd_stb), 0);
    checkOutput({tag, "_cmd_data"}, 32'(bus.o_cmd_data), 0);
    checkOutput({tag, "_con_stb"}, 32'(bus.o_console_stb), 0);
    checkOutput({tag, "_con_data"}, 32'(bus.o_console_data), 0);
    checkOutput({tag, "_cmd_busy"}, 32'(bus.o_cmd_busy), 0);
    checkOutput({tag, "_con_busy"}, 32'(bus.o_console_busy), 0);
  endtask

  initial begin
    logic [7*NCH-1:0] cd;
    logic [NCH-1:0]   cs;
    logic [7:0]       rb;
    int               r;
    modelReset();
    bus.i_rx_stb = 1'b0; bus.i_rx_data = '0; bus.i_cmd_stb = 1'b0; bus.i_cmd_data = '0;
    bus.i_console_stb = '0; bus.i_console_data = '0; bus.i_tx_busy = 1'b0;
    #12;
    checkAllZero("reset");
    @(posedge clk); #3 rst_n = 1'b1;

    $display("[TB] rx decoder scenarios");
    sendRx(8'h41); sendRx(8'hC1);
    sendRx(8'h7F); sendRx(8'h01); sendRx(8'h42);
    sendRx(8'h7F); sendRx(8'h7F);
    sendRx(8'h7F); sendRx(8'h05);
    idleCycles(3);

`ifdef CONSOLE_MUX_CMDGATE_EN
    $display("[TB] command gate scenario");
    applyStimulus(1'b0, 8'h00, 1'b1, 7'h2A, '0, '0, 1'b0);
    idleCycles(8);
    sendRx(8'h80);
    idleCycles(4);
`endif

    $display("[TB] console select and escape");
    cd = '0; cd[13:7] = 7'h33;
    applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 2'b10, cd, 1'b0);
    idleCycles(5);
    cd[13:7] = 7'h7F;
    applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 2'b10, cd, 1'b0);
    idleCycles(5);

    $display("[TB] command burst limit");
    for (int i = 0; i < 14; i++) begin
      cd = '0; cd[6:0] = 7'h20;
      applyStimulus(1'b0, 8'h00, 1'b1, 7'(i + 1), (i == 0) ? 2'b01 : 2'b00, cd, 1'b0);
    end
    idleCycles(6);

    $display("[TB] transmitter stall");
    cd = '0; cd[6:0] = 7'h11;
    applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 2'b01, cd, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 2'b00, cd, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, '0, '0, 1'b1);
    idleCycles(15);

    $display("[TB] reset in the middle of a select sequence");
    cd = '0; cd[13:7] = 7'h66;
    applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 2'b10, cd, 1'b0);
    idleCycles(1);
    @(posedge clk); #3;
    bus.i_console_stb = '0; rst_n = 1'b0;
    #1 checkAllZero("midreset");
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    cd = '0; cd[6:0] = 7'h55;
    applyStimulus(1'b0, 8'h00, 1'b0, 7'h00, 2'b01, cd, 1'b0);
    idleCycles(6);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) rb = 8'h7F;
      else if (r < 5) rb = 8'($urandom_range(0, 3));
      else if (r < 7) rb = 8'h80 | 8'($urandom_range(0, 127));
      else rb = 8'($urandom_range(0, 255));
      for (int c = 0; c < NCH; c++) begin
        cs[c] = ($urandom_range(0, 2) == 0);
        cd[7*c +: 7] = ($urandom_range(0, 4) == 0) ? 7'h7F : 7'($urandom_range(0, 127));
      end
      applyStimulus($urandom_range(0, 3) == 0, rb, $urandom_range(0, 3) == 0,
                    7'($urandom_range(0, 127)), cs, cd, $urandom_range(0, 2) == 0);
    end
    sendRx(8'h80);
    idleCycles(60);

    checkOutput("tx_queue_drained", 32'(txExpQ.size()), 0);
    checkOutput("cmd_queue_drained", 32'(cmdExpQ.size()), 0);
    checkOutput("console_queue_drained", 32'(conChanQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
